pwm_backlight_ctrl: RTL

Parametrised PWM backlight controller with configurable duty resolution, clock prescaler, output polarity and optional smooth fade between brightness levels. Duty updates are double-buffered and take effect only on PWM period boundaries, so the output never glitches. It drives the LCD backlight enable pin, and system control logic loads a target brightness through a single-cycle strobe.

---
 rtl/pwm_backlight_ctrl.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/pwm_backlight_ctrl.sv
// PWM backlight driver: prescaled counter, double-buffered duty, selectable output polarity.
// Define PWM_BL_FADE_EN to compile in the fade FSM; otherwise duty changes apply in one step.
module pwm_backlight_ctrl #(
  parameter int CNT_W      = 8,
  parameter int PRESC      = 16,
  parameter int STEP_TICKS = 4,
  parameter bit POLARITY   = 1'b1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             Enable,
  input  logic [CNT_W-1:0] Duty_Val,
  input  logic             Duty_Load,
  output logic             BackLight_OUT,
  output logic [CNT_W-1:0] Duty_Cur,
  output logic             Busy,
  output logic             Period_Start
);

  localparam int PRESC_W = (PRESC > 1) ? $clog2(PRESC) : 1;
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(PRESC - 1);
  // Counter tops out one below all-ones so duty = all-ones is solidly on.
  localparam logic [CNT_W-1:0] PWM_LAST = CNT_W'((1 << CNT_W) - 2);

  generate
    if (CNT_W < 2 || CNT_W > 16 || PRESC < 1 || STEP_TICKS < 1) begin : g_param_err
      $error("pwm_backlight_ctrl: parameter out of legal range");
    end
  endgenerate

  logic [PRESC_W-1:0] presc_cnt_reg;
  logic [CNT_W-1:0]   pwm_cnt_reg;
  logic [CNT_W-1:0]   target_reg;
  logic [CNT_W-1:0]   duty_cur_reg;
  logic               tick;
  logic               wrap;
  logic               active;

  assign tick   = Enable && (presc_cnt_reg == PRESC_LAST);
  assign wrap   = tick && (pwm_cnt_reg == PWM_LAST);
  assign active = pwm_cnt_reg < duty_cur_reg;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      presc_cnt_reg <= '0;
    end else if (!Enable || tick) begin
      presc_cnt_reg <= '0;
    end else begin
      presc_cnt_reg <= presc_cnt_reg + PRESC_W'(1);
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      pwm_cnt_reg <= '0;
    end else if (!Enable || wrap) begin
      pwm_cnt_reg <= '0;
    end else if (tick) begin
      pwm_cnt_reg <= pwm_cnt_reg + CNT_W'(1);
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      BackLight_OUT <= ~POLARITY;
      Period_Start  <= 1'b0;
    end else begin
      BackLight_OUT <= (Enable && active) ? POLARITY : ~POLARITY;
      Period_Start  <= wrap;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      target_reg <= '0;
    end else if (Duty_Load) begin
      target_reg <= Duty_Val;
    end
  end

`ifdef PWM_BL_FADE_EN
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RAMP = 1'b1;
  localparam int STEP_W = (STEP_TICKS > 1) ? $clog2(STEP_TICKS) : 1;
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEP_TICKS - 1);

  logic [0:0]        state_reg;
  logic [STEP_W-1:0] step_cnt_reg;
  logic              step_due;

  assign step_due = (state_reg == ST_RAMP) && wrap && (step_cnt_reg == STEP_LAST);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_reg    <= ST_IDLE;
      step_cnt_reg <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          step_cnt_reg <= '0;
          if (target_reg != duty_cur_reg) begin
            state_reg <= ST_RAMP;
          end
        end
        default: begin
          if (target_reg == duty_cur_reg) begin
            state_reg <= ST_IDLE;
          end
          if (!Enable || step_due) begin
            step_cnt_reg <= '0;
          end else if (wrap) begin
            step_cnt_reg <= step_cnt_reg + STEP_W'(1);
          end
        end
      endcase
    end
  end

  // A retarget mid-ramp simply changes direction from wherever the shadow sits.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      duty_cur_reg <= '0;
    end else if (step_due && (target_reg > duty_cur_reg)) begin
      duty_cur_reg <= duty_cur_reg + CNT_W'(1);
    end else if (step_due && (target_reg < duty_cur_reg)) begin
      duty_cur_reg <= duty_cur_reg - CNT_W'(1);
    end
  end

  assign Busy = (state_reg == ST_RAMP);
`else
  logic busy_reg;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      duty_cur_reg <= '0;
      busy_reg     <= 1'b0;
    end else begin
      if (wrap) begin
        duty_cur_reg <= target_reg;
      end
      busy_reg <= (target_reg != duty_cur_reg);
    end
  end

  assign Busy = busy_reg;
`endif

  assign Duty_Cur = duty_cur_reg;

endmodule
